// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings, the zero register,
// and the destination/source register match used by hazard detection.
package hazard_unit_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] BR_LOAD2 = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Writes to r0 are discarded, so they can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dest,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_stall_counter.sv
// Saturating 32-bit counter of cycles in which the PC was held; only
// instantiated when HAZARD_STATS_EN is defined.
module stall_counter
  import hazard_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        count_en,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count enabled cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 32'd0;
    end else if (count_en && (count_r != 32'hFFFF_FFFF)) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / branch stalls, branch flush and memory freeze.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_UsesRT,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic [4:0]  EX_RT,
  input  logic [4:0]  EX_RD,
  input  logic        EX_RegDst,
  input  logic        EX_RegWrite,
  input  logic        EX_MEM_REN,
  input  logic        MEM_Busy,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Pipe_Freeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCycles
`endif
);

  logic [1:0] state_r, saved_r;
  logic [1:0] next_state_s, next_saved_s, eff_state_s;
  logic [4:0] ex_dest_s;
  logic       match_s, load_use_s, br_alu_s, br_load_s;
  logic       pc_write_s, if_id_write_s, flush_s, bubble_s, freeze_s;

  assign ex_dest_s  = EX_RegDst ? EX_RD : EX_RT;
  assign match_s    = reg_match(ex_dest_s, ID_RS, ID_RT, ID_UsesRT);
  assign load_use_s = EX_MEM_REN && match_s && !ID_Branch;
  assign br_alu_s   = ID_Branch && EX_RegWrite && !EX_MEM_REN && match_s;
  assign br_load_s  = ID_Branch && EX_MEM_REN && match_s;
  // Once memory is ready again, the saved state acts in the same cycle.
  assign eff_state_s = (state_r == MEM_WAIT) ? saved_r : state_r;

  // Next-state and output decode, in priority order reset > freeze > stall > flush.
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    flush_s       = 1'b0;
    bubble_s      = 1'b0;
    freeze_s      = 1'b0;
    next_state_s  = state_r;
    next_saved_s  = saved_r;
    if (reset) begin
      next_state_s = RUN;
      next_saved_s = RUN;
    end else if (MEM_Busy) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      freeze_s      = 1'b1;
      next_state_s  = MEM_WAIT;
      if (state_r != MEM_WAIT) begin
        next_saved_s = state_r;
      end else begin
        next_saved_s = saved_r;
      end
    end else begin
      next_saved_s = RUN;
      case (eff_state_s)
        BR_LOAD2: begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          bubble_s      = 1'b1;
          next_state_s  = RUN;
        end
        RUN: begin
          if (load_use_s || br_alu_s || br_load_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            bubble_s      = 1'b1;
            next_state_s  = br_load_s ? BR_LOAD2 : RUN;
          end else begin
            flush_s      = ID_BranchTaken;
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  // State and saved-state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      saved_r <= RUN;
    end else begin
      state_r <= next_state_s;
      saved_r <= next_saved_s;
    end
  end

  assign PC_Write     = pc_write_s;
  assign IF_ID_Write  = if_id_write_s;
  assign IF_ID_Flush  = flush_s;
  assign ID_EX_Bubble = bubble_s;
  assign Pipe_Freeze  = freeze_s;

`ifdef HAZARD_STATS_EN
  stall_counter u_stall_counter (
    .clock    (clock),
    .reset    (reset),
    .count_en (!pc_write_s),
    .count    (StallCycles)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for single-cycle decode plus
// hand sequences for multi-cycle stalls, freezes and reset. Counter checks need HAZARD_STATS_EN.
module tb_hazard_unit;

  logic       clock, reset;
  logic [4:0] ID_RS, ID_RT, EX_RT, EX_RD;
  logic       ID_UsesRT, ID_Branch, ID_BranchTaken;
  logic       EX_RegDst, EX_RegWrite, EX_MEM_REN, MEM_Busy;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCycles;
`endif

  int total = 0;
  int bad   = 0;

  hazard_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ID_RS          (ID_RS),
    .ID_RT          (ID_RT),
    .ID_UsesRT      (ID_UsesRT),
    .ID_Branch      (ID_Branch),
    .ID_BranchTaken (ID_BranchTaken),
    .EX_RT          (EX_RT),
    .EX_RD          (EX_RD),
    .EX_RegDst      (EX_RegDst),
    .EX_RegWrite    (EX_RegWrite),
    .EX_MEM_REN     (EX_MEM_REN),
    .MEM_Busy       (MEM_Busy),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .Pipe_Freeze    (Pipe_Freeze)
`ifdef HAZARD_STATS_EN
    ,
    .StallCycles    (StallCycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
  localparam logic [4:0] NONE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] FRZ   = 5'b00001;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, br, tk;
    logic [4:0] ex_rt, ex_rd;
    logic       regdst, regwr, ren, busy;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[13];
  vec_t v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, check outputs mid-cycle, then advance one clock.
  task automatic run(input vec_t x);
    ID_RS = x.rs; ID_RT = x.rt; ID_UsesRT = x.uses_rt;
    ID_Branch = x.br; ID_BranchTaken = x.tk;
    EX_RT = x.ex_rt; EX_RD = x.ex_rd; EX_RegDst = x.regdst;
    EX_RegWrite = x.regwr; EX_MEM_REN = x.ren; MEM_Busy = x.busy;
    @(negedge clock);
    check(x.name, {27'd0, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze},
          {27'd0, x.exp});
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  "idle"};
    tbl[1]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL, "lu_rs"};
    tbl[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, NONE,  "zero_reg"};
    tbl[3]  = '{5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, STALL, "lu_rt_rd"};
    tbl[4]  = '{5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, NONE,  "lu_rt_unused"};
    tbl[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, NONE,  "lu_dest_rd"};
    tbl[6]  = '{5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, STALL, "br_alu"};
    tbl[7]  = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, FLUSH, "br_taken"};
    tbl[8]  = '{5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, NONE,  "br_nowrite"};
    tbl[9]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, NONE,  "alu_fwd"};
    tbl[10] = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, FRZ,   "busy_lu"};
    tbl[11] = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL, "after_busy_lu"};
    tbl[12] = '{5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FLUSH, "br_zero_dest"};

    // Reset forces outputs even with a load-use hazard present.
    reset = 1'b1;
    v = tbl[1]; v.exp = NONE; v.name = "reset_forced";
    run(v);
    run(v);
    reset = 1'b0;

    // Branch-load: two stall cycles, then back to normal.
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL, "brld_c1"});
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STALL, "brld_c2"});
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE,  "brld_done"});

    // Load-use: one stall, then EX holds the bubble.
    run(tbl[1]);
    run('{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "lu_done"});
`ifdef HAZARD_STATS_EN
    check("stall_count", StallCycles, 32'd3);
`endif

    for (int i = 0; i < 13; i++) run(tbl[i]);

    // Freeze for three cycles in the middle of a branch-load stall.
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL, "frz_c1"});
    for (int i = 0; i < 3; i++)
      run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, "frz_hold"});
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STALL, "frz_resume"});
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH, "frz_done"});

    // Flush suppressed while a branch-ALU hazard stalls, then released.
    run('{5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, STALL, "sup_stall"});
    run('{5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH, "sup_flush"});

    // Reset in BR_LOAD2 abandons the remaining stall cycle.
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL, "rst_brld"});
    reset = 1'b1;
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "rst_mid"});
`ifdef HAZARD_STATS_EN
    check("stall_count_rst", StallCycles, 32'd0);
`endif
    reset = 1'b0;
    run('{5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, "rst_after1"});
    run(tbl[0]);

    // Reset during a freeze also leaves no residue.
    run(tbl[10]);
    reset = 1'b1;
    run('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE, "rst_frz"});
    reset = 1'b0;
    run('{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FLUSH, "rst_frz_after"});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ID_RS, input, 5 bits: rs of the instruction in ID.
REQ-004 SHALL have port ID_RT, input, 5 bits: rt of the instruction in ID.
REQ-005 SHALL have port ID_UsesRT, input, 1 bit: the ID instruction reads rt as a source.
REQ-006 SHALL have port ID_Branch, input, 1 bit: the ID instruction is a branch that compares registers in ID.
REQ-007 SHALL have port ID_BranchTaken, input, 1 bit: branch resolved taken in ID.
REQ-008 SHALL have ports EX_RT, EX_RD (input, 5 bits each) and EX_RegDst, EX_RegWrite, EX_MEM_REN (input, 1 bit each): ID/EX register outputs.
REQ-009 SHALL have port MEM_Busy, input, 1 bit: data memory not ready, so the whole pipe must hold.
REQ-010 SHALL have ports PC_Write and IF_ID_Write, output, 1 bit each: enables for the PC and IF/ID registers.
REQ-011 SHALL have ports IF_ID_Flush, ID_EX_Bubble and Pipe_Freeze, output, 1 bit each: zero IF/ID, zero ID/EX controls, and hold all pipeline registers.

Function
REQ-012 SHALL compute EX_Dest = EX_RegDst ? EX_RD : EX_RT.
- A "match" SHALL require EX_Dest != 0.
- A match SHALL also require EX_Dest == ID_RS, or (ID_UsesRT and EX_Dest == ID_RT).
REQ-013 SHALL use states RUN, BR_LOAD2 and MEM_WAIT, registered on clock; reset state is RUN.
REQ-014 In RUN, load-use (EX_MEM_REN and match, ID_Branch=0) SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly one cycle.
REQ-015 In RUN, branch-ALU (ID_Branch, EX_RegWrite, EX_MEM_REN=0, match) SHALL stall one cycle with the same outputs as REQ-014.
REQ-016 In RUN, branch-load (ID_Branch, EX_MEM_REN, match) SHALL stall this cycle and transition to BR_LOAD2.
REQ-017 In BR_LOAD2, the unit SHALL stall one more cycle unconditionally (same outputs as REQ-014), then return to RUN; total stall is 2 cycles.
REQ-018 IF_ID_Flush SHALL equal ID_BranchTaken only in RUN with no stall condition active; it SHALL be suppressed during any stall or freeze.
REQ-019 When MEM_Busy=1 in any state, the unit SHALL:
- save the current state and enter MEM_WAIT;
- drive Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
REQ-020 In MEM_WAIT, when MEM_Busy=0 the unit SHALL return to the saved state, so a BR_LOAD2 stall interrupted by a freeze still completes.
REQ-021 Priority SHALL be: MEM_Busy > BR_LOAD2 > load-use/branch hazards > branch flush.
REQ-022 All outputs SHALL be combinational from state and inputs, giving zero-cycle detection latency.
REQ-023 With no hazard, outputs SHALL be PC_Write=1, IF_ID_Write=1, and all others 0.

Reset
REQ-024 On reset assertion the state SHALL go to RUN immediately and the saved state SHALL clear to RUN.
REQ-025 While reset=1, outputs SHALL be forced regardless of inputs:
- PC_Write=1, IF_ID_Write=1;
- IF_ID_Flush=0, ID_EX_Bubble=0, Pipe_Freeze=0;
- StallCycles=0.
REQ-026 Reset asserted mid-stall (BR_LOAD2 or MEM_WAIT) SHALL abandon the stall with no residual cycle after release.

Configuration
REQ-027 Macro HAZARD_STATS_EN SHALL control the stall-cycle counter.
- Defined: output port StallCycles (32 bits) counts cycles with PC_Write=0, saturates at 0xFFFFFFFF and resets to 0.
- Undefined: neither the port nor the counter logic exists.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-028 State encodings (RUN=2'd0, BR_LOAD2=2'd1, MEM_WAIT=2'd2) and REG_ZERO=5'd0 SHALL live in the shared CPU package/header.
REQ-029 The counter SHALL be the sub-module stall_counter, instantiated only under HAZARD_STATS_EN.

Verification
REQ-030 Load-use: EX_MEM_REN=1, EX_RegDst=0, EX_RT=5, ID_RS=5 -> one cycle PC_Write=0, ID_EX_Bubble=1, then PC_Write=1.
REQ-031 Branch-load: ID_Branch=1, EX_MEM_REN=1, EX_RT=8, ID_RT=8, ID_UsesRT=1 -> two stall cycles (RUN then BR_LOAD2), then RUN.
REQ-032 Zero register: EX_MEM_REN=1, EX_RT=0, ID_RS=0 -> no stall, PC_Write=1.
REQ-033 Freeze mid-stall: MEM_Busy=1 for 3 cycles during BR_LOAD2 -> Pipe_Freeze=1 for 3 cycles, then one BR_LOAD2 stall cycle, then RUN.
REQ-034 Flush suppression: ID_BranchTaken=1 with a branch-ALU hazard on EX_RD=3 (RegDst=1) -> IF_ID_Flush=0 for the stall cycle, then 1 once resolved.
REQ-035 Counter, with HAZARD_STATS_EN: after the REQ-031 and REQ-030 sequences -> StallCycles=3; after reset -> StallCycles=0.
